// File: rtl/link_serdes_pkg.sv
// Shared types and helpers for the forwarded-clock serial link endpoint.
package link_serdes_pkg;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  // Bits on the wire per frame: start + payload + stop.
  function automatic int frame_bits(input int data_width);
    return data_width + 2;
  endfunction

endpackage

// File: rtl/link_fifo.sv
// Synchronous FIFO with count-based full/empty. A pop on a full FIFO frees the
// slot for a push in the same cycle. Storage is reset so the head reads 0.
module link_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count == CW'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  // Pointer, occupancy and storage update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/link_serdes.sv
// Forwarded-clock serial link endpoint: TX FIFO + serialiser driving a divided
// link clock, and a synchronised RX deserialiser feeding an RX FIFO.
// Handshakes: a word moves on tx_data when tx_valid && tx_ready at a rising
// clk edge; rx_data is popped when rx_valid && rx_ready at a rising clk edge.
module link_serdes
  import link_serdes_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CLK_DIV    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  tx_busy,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  rx_overflow,
  output logic                  rx_frame_err,
  input  logic                  err_clr,
  output logic                  link_clk_out,
  output logic                  link_txd,
  input  logic                  link_clk_in,
  input  logic                  link_rxd
);

  localparam int DIVW = $clog2(CLK_DIV);
  localparam int BW   = $clog2(frame_bits(DATA_WIDTH));
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  // ---------------- link clock divider ----------------
  logic [DIVW-1:0] div_cnt;
  logic            div_tc;
  logic            link_fall;

  assign div_tc    = (div_cnt == DIVW'(CLK_DIV - 1));
  assign link_fall = div_tc && link_clk_out;

  // Free-running divider; link clock toggles at terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt      <= '0;
      link_clk_out <= 1'b0;
    end else if (div_tc) begin
      div_cnt      <= '0;
      link_clk_out <= ~link_clk_out;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // ---------------- transmit path ----------------
  tx_state_e             tx_state, tx_state_n;
  logic [DATA_WIDTH-1:0] tx_shift, tx_shift_n;
  logic [BW-1:0]         tx_bit, tx_bit_n;
  logic                  txd_n;
  logic                  tx_pop;
  logic                  tx_full, tx_empty;
  logic [DATA_WIDTH-1:0] tx_head;

  assign tx_ready = !tx_full;
  assign tx_busy  = (tx_state != TX_IDLE) || !tx_empty;

  link_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (tx_valid && tx_ready),
    .wr_data (tx_data),
    .pop     (tx_pop),
    .rd_data (tx_head),
    .full    (tx_full),
    .empty   (tx_empty)
  );

  // TX state register and line driver.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      tx_shift <= '0;
      tx_bit   <= '0;
      link_txd <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_shift <= tx_shift_n;
      tx_bit   <= tx_bit_n;
      link_txd <= txd_n;
    end
  end

  // TX next state: everything advances only on a falling link-clock edge.
  always_comb begin
    tx_state_n = tx_state;
    tx_shift_n = tx_shift;
    tx_bit_n   = tx_bit;
    txd_n      = link_txd;
    tx_pop     = 1'b0;
    if (link_fall) begin
      case (tx_state)
        TX_IDLE, TX_STOP: begin
          if (!tx_empty) begin
            tx_pop     = 1'b1;
            tx_shift_n = tx_head;
            txd_n      = 1'b0;
            tx_state_n = TX_START;
          end else begin
            txd_n      = 1'b1;
            tx_state_n = TX_IDLE;
          end
        end
        TX_START: begin
          txd_n      = tx_shift[0];
          tx_shift_n = tx_shift >> 1;
          tx_bit_n   = '0;
          tx_state_n = TX_DATA;
        end
        TX_DATA: begin
          if (tx_bit == LAST_BIT) begin
            txd_n      = 1'b1;
            tx_state_n = TX_STOP;
          end else begin
            txd_n      = tx_shift[0];
            tx_shift_n = tx_shift >> 1;
            tx_bit_n   = tx_bit + 1'b1;
          end
        end
        default: tx_state_n = TX_IDLE;
      endcase
    end
  end

  // ---------------- receive path ----------------
  logic [1:0]            clk_sync, rxd_sync;
  logic                  clk_prev;
  logic                  sample_en, sample_bit;
  rx_state_e             rx_state, rx_state_n;
  logic [DATA_WIDTH-1:0] rx_shift, rx_shift_n;
  logic [BW-1:0]         rx_bit, rx_bit_n;
  logic                  rx_push, frame_set, overflow_set;
  logic                  rx_full, rx_empty;

  assign rx_valid     = !rx_empty;
  assign overflow_set = rx_push && rx_full && !(rx_ready && rx_valid);

  // Two-flop synchronisers, edge-detect flop and registered sample strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync   <= '0;
      rxd_sync   <= 2'b11;
      clk_prev   <= 1'b0;
      sample_en  <= 1'b0;
      sample_bit <= 1'b1;
    end else begin
      clk_sync   <= {clk_sync[0], link_clk_in};
      rxd_sync   <= {rxd_sync[0], link_rxd};
      clk_prev   <= clk_sync[1];
      sample_en  <= clk_sync[1] && !clk_prev;
      sample_bit <= rxd_sync[1];
    end
  end

  // RX state register and sticky error flags (a new event beats err_clr).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state     <= RX_IDLE;
      rx_shift     <= '0;
      rx_bit       <= '0;
      rx_overflow  <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_state     <= rx_state_n;
      rx_shift     <= rx_shift_n;
      rx_bit       <= rx_bit_n;
      rx_overflow  <= overflow_set || (rx_overflow && !err_clr);
      rx_frame_err <= frame_set || (rx_frame_err && !err_clr);
    end
  end

  // RX next state: one step per synchronised rising link-clock edge.
  always_comb begin
    rx_state_n = rx_state;
    rx_shift_n = rx_shift;
    rx_bit_n   = rx_bit;
    rx_push    = 1'b0;
    frame_set  = 1'b0;
    if (sample_en) begin
      case (rx_state)
        RX_IDLE: begin
          if (!sample_bit) begin
            rx_bit_n   = '0;
            rx_state_n = RX_DATA;
          end
        end
        RX_DATA: begin
          rx_shift_n = (rx_shift >> 1) | (DATA_WIDTH'(sample_bit) << (DATA_WIDTH - 1));
          if (rx_bit == LAST_BIT) rx_state_n = RX_STOP;
          else                    rx_bit_n   = rx_bit + 1'b1;
        end
        RX_STOP: begin
          if (sample_bit) rx_push   = 1'b1;
          else            frame_set = 1'b1;
          rx_state_n = RX_IDLE;
        end
        default: rx_state_n = RX_IDLE;
      endcase
    end
  end

  link_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (rx_push),
    .wr_data (rx_shift),
    .pop     (rx_ready),
    .rd_data (rx_data),
    .full    (rx_full),
    .empty   (rx_empty)
  );

endmodule

// File: doc/link_serdes.md
# link_serdes

Parametrised forwarded-clock serial link endpoint for the board-level debug link pins (the jd_* PMOD header on the Arty100T shell). Transmit side: buffers parallel words and serialises them onto a data line, alongside a free-running link clock it generates. Receive side: synchronises an incoming link clock/data pair, deserialises frames into a buffered valid/ready stream and flags framing and overflow errors. Width, buffer depth and bit rate are parameters.

## Interface
- DATA_WIDTH, 8: payload bits per frame, ≥1
- FIFO_DEPTH, 4: entries in each of the TX and RX FIFOs, power of 2, ≥2
- CLK_DIV, 4: clk cycles per link-clock half-period, ≥2
- clk  in  1  system clock; the only clock
- rst_n  in  1  reset, asynchronous, active-low
- tx_data  in  DATA_WIDTH  word to send
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  TX FIFO not full
- tx_busy  out  1  frame in flight or TX FIFO non-empty
- rx_data  out  DATA_WIDTH  head of RX FIFO
- rx_valid  out  1  RX FIFO non-empty
- rx_ready  in  1  consumer pops rx_data
- rx_overflow  out  1  sticky: received word dropped, RX FIFO full
- rx_frame_err  out  1  sticky: stop bit sampled 0
- err_clr  in  1  clears both sticky flags
- link_clk_out  out  1  forwarded link clock
- link_txd  out  1  serial data out
- link_clk_in  in  1  received link clock, asynchronous
- link_rxd  in  1  received serial data, asynchronous

## Operation
- Frame: start bit 0, DATA_WIDTH bits LSB-first, stop bit 1; idle line 1.
- Link clock: free-running divider counts 0..CLK_DIV-1 and toggles link_clk_out at terminal count. One bit = one link-clock period = 2*CLK_DIV cycles.
- TX FSM: TX_IDLE → TX_START → TX_DATA → TX_STOP.
  - All state changes and link_txd updates occur only on the cycle link_clk_out toggles 1→0 (falling edge).
  - TX_IDLE pops the FIFO into the shift register at a falling edge when non-empty.
  - TX_DATA holds DATA_WIDTH bits, then goes to TX_STOP.
  - TX_STOP → TX_START directly if the FIFO is non-empty (no idle gap), else → TX_IDLE.
- RX path:
  - link_clk_in and link_rxd each pass through a 2-flop synchroniser.
  - A rising edge of the synchronised clock, detected against a third flop, produces one sample of the synchronised rxd.
  - RX FSM: RX_IDLE (wait for a sample = 0) → RX_DATA (DATA_WIDTH samples, LSB-first) → RX_STOP.
  - RX_STOP, sample 1: push word; if the FIFO is full, drop the word and set rx_overflow.
  - RX_STOP, sample 0: drop the word and set rx_frame_err.
  - RX_STOP always returns to RX_IDLE.
- Pop and push in the same cycle on a full RX FIFO: pop is applied first, push is accepted, no overflow.
- err_clr coincident with a new error event: the flag stays set (set wins).
- Capacity: FIFO_DEPTH queued words plus 1 in the TX shifter.

## Timing
- Reset values:
  - tx_ready=1, tx_busy=0, rx_valid=0, rx_data=0
  - rx_overflow=0, rx_frame_err=0
  - link_clk_out=0, link_txd=1
  - both FSMs idle, both FIFOs empty, divider=0
- rst_n assertion mid-frame takes effect immediately (async): link_txd=1 and both FIFOs are emptied. No partial word is emitted after release.
- tx_valid&&tx_ready at cycle t: the word is in the FIFO at t+1. The start bit begins at the first falling link edge after t+1.
- Frame duration on the wire: (DATA_WIDTH+2)*2*CLK_DIV cycles.
- RX: rx_valid rises 4 cycles after the raw rising edge of link_clk_in carrying the stop bit (2 sync, 1 edge detect, 1 push).
- rx_data is valid whenever rx_valid=1 and is stable until popped.

## Structure
- Package link_serdes_pkg: tx_state_e and rx_state_e enums, plus a frame_bits(DATA_WIDTH) constant function.
- Sub-module link_fifo: parametrised synchronous FIFO (DATA_WIDTH, FIFO_DEPTH) with count-based full/empty. Instantiated twice, once for TX and once for RX.
- Divider, both FSMs and the synchronisers live in link_serdes.

## Test plan
- Loopback (link_clk_out→link_clk_in, link_txd→link_rxd), DATA_WIDTH=8, CLK_DIV=4, send 0xA5 → link_txd bits 0,1,0,1,0,0,1,0,1,1, each 8 cycles, 80-cycle frame; rx_data=0xA5, rx_valid for one pop.
- Loopback, push 0x01..0x06 back-to-back, rx_ready=1 → tx_ready drops once 4 are queued; all six arrive in order; no idle bit between frames.
- Loopback, rx_ready=0, send 0x01..0x05 → rx_overflow=1; draining yields 0x01..0x04; err_clr → rx_overflow=0.
- Bench drives link_clk_in/link_rxd with payload 0x3C and stop bit 0 → no rx_valid, rx_frame_err=1; the next valid frame 0x3C is received normally.
- rst_n low during data bit 3 of 0xFF → link_txd=1 in the same cycle, tx_ready=1, tx_busy=0; after release link_txd stays 1 with no frame.
- DATA_WIDTH=16, CLK_DIV=2 loopback of 0xBEEF → 72-cycle frame, rx_data=0xBEEF.
